// File: rtl/rst_seq_pkg.sv
// Shared types for the staged reset sequencer and its bench.
package rst_seq_pkg;

    typedef enum logic [2:0] {
        HOLD     = 3'd0,
        WAIT_ACK = 3'd1,
        GAP      = 3'd2,
        RUN      = 3'd3,
        FAULT    = 3'd4
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/rst_seq_ctrl.sv
// Staged reset sequencer: hold all stages, then release one at a time on ack,
// flag timeouts and ack loss, restart on soft reset.
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int NUM_STG  = 4,
    parameter int HOLD_CYC = 1024,
    parameter int STG_GAP  = 256,
    parameter int ACK_TO   = 65535
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       soft_rst_req,
    input  logic [NUM_STG-1:0]         stage_ack,
    output logic [NUM_STG-1:0]         stg_rst_n,
    output logic                       all_ready,
    output logic                       seq_err,
    output logic [$clog2(NUM_STG)-1:0] err_stage
);

    localparam int IW   = $clog2(NUM_STG);
    localparam int MAXC = max3(HOLD_CYC, STG_GAP, ACK_TO);
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(STG_GAP - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(ACK_TO - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_STG - 1);

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [NUM_STG-1:0]   stg_q, stg_d;
    logic                 rdy_q, rdy_d;
    logic                 err_q, err_d;
    logic [IW-1:0]        es_q, es_d;

    logic                 go_fault;
    logic [IW-1:0]        fault_idx;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        stg_d     = stg_q;
        rdy_d     = rdy_q;
        err_d     = err_q;
        es_d      = es_q;
        go_fault  = 1'b0;
        fault_idx = '0;

        if (soft_rst_req) begin
            state_d = HOLD;
            cnt_d   = '0;
            idx_d   = '0;
            stg_d   = '0;
            rdy_d   = 1'b0;
            err_d   = 1'b0;
            es_d    = '0;
        end else begin
            case (state_q)
                HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        stg_d[0] = 1'b1;
                        idx_d    = '0;
                        cnt_d    = '0;
                        state_d  = WAIT_ACK;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                WAIT_ACK: begin
                    if (stage_ack[idx_q]) begin
                        if (idx_q == IDX_LAST) begin
                            state_d = RUN;
                            rdy_d   = 1'b1;
                        end else begin
                            cnt_d   = '0;
                            state_d = GAP;
                        end
                    end else if (cnt_q == TO_LAST) begin
                        go_fault  = 1'b1;
                        fault_idx = idx_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        idx_d        = IW'(idx_q + 1'b1);
                        stg_d[idx_d] = 1'b1;
                        cnt_d        = '0;
                        state_d      = WAIT_ACK;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    // Downward scan so the lowest dropped ack wins.
                    if (!(&stage_ack)) begin
                        go_fault = 1'b1;
                        for (int i = NUM_STG - 1; i >= 0; i--) begin
                            if (!stage_ack[i]) fault_idx = IW'(i);
                        end
                    end
                end
                FAULT: ;
                default: state_d = HOLD;
            endcase

            if (go_fault) begin
                state_d = FAULT;
                err_d   = 1'b1;
                es_d    = fault_idx;
                rdy_d   = 1'b0;
                for (int i = 0; i < NUM_STG; i++) begin
                    if (i >= int'(fault_idx)) stg_d[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HOLD;
            cnt_q   <= '0;
            idx_q   <= '0;
            stg_q   <= '0;
            rdy_q   <= 1'b0;
            err_q   <= 1'b0;
            es_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            stg_q   <= stg_d;
            rdy_q   <= rdy_d;
            err_q   <= err_d;
            es_q    <= es_d;
        end
    end

    assign stg_rst_n = stg_q;
    assign all_ready = rdy_q;
    assign seq_err   = err_q;
    assign err_stage = es_q;

endmodule

// File: doc/rst_seq_ctrl.md
# rst_seq_ctrl

Staged reset sequencer for the quadcopter's synchronous domain. It sits downstream of the reset synchronizer and holds every subsystem in reset for a settle period. It then releases up to NUM_STG subsystem resets one at a time (for example SPI/inertial front end, then flight controller, then ESC/PWM), waiting for each stage's ready acknowledge before releasing the next. It reports completion, detects per-stage ack timeouts and ack loss, and re-sequences on a soft reset request.

## Interface
- NUM_STG, 4: number of sequenced stages (≥2).
- HOLD_CYC, 1024: cycles all stages are held in reset after `rst_n` release or a soft reset (≥1).
- STG_GAP, 256: idle cycles between one stage's ack and the next stage's release (≥1).
- ACK_TO, 65535: cycles allowed for a released stage to assert its ack (≥1).
- clk  in  1  system clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset (already synchronized upstream).
- soft_rst_req  in  1  synchronous pulse: restart the sequence from HOLD.
- stage_ack  in  NUM_STG  per-stage ready, synchronous to `clk`, level-sensitive.
- stg_rst_n  out  NUM_STG  per-stage active-low reset, registered.
- all_ready  out  1  all stages released and acked, registered.
- seq_err  out  1  sticky fault flag, registered.
- err_stage  out  $clog2(NUM_STG)  index of the faulting stage, valid while `seq_err`=1.

## Operation
- Reset (`rst_n`=0, asynchronous) forces:
  - state=HOLD, idx=0, cnt=0
  - `stg_rst_n`=0, `all_ready`=0, `seq_err`=0, `err_stage`=0
- FSM states and transitions:
  - **HOLD:** cnt increments each edge. When cnt==HOLD_CYC-1: set `stg_rst_n[0]`=1, idx=0, cnt=0, go to WAIT_ACK.
  - **WAIT_ACK:** if `stage_ack[idx]`=1:
    - if idx==NUM_STG-1, go to RUN and set `all_ready`=1;
    - otherwise cnt=0 and go to GAP.
    - Else if cnt==ACK_TO-1, go to FAULT. Otherwise cnt increments.
  - **GAP:** cnt increments. When cnt==STG_GAP-1: idx++, set `stg_rst_n[idx]`=1, cnt=0, go to WAIT_ACK.
  - **RUN:** hold outputs. If any `stage_ack` bit drops, go to FAULT with err index = the lowest dropped bit.
  - **FAULT (entry edge):**
    - `seq_err`=1, `err_stage`=faulting index, `all_ready`=0;
    - `stg_rst_n` bits at the faulting index and above are forced to 0; lower bits keep their value.
    - Stays in FAULT until `soft_rst_req`.
- `soft_rst_req`=1 has priority over every other transition, in every state. On that edge:
  - state=HOLD, cnt=0, idx=0;
  - `stg_rst_n`=0, `all_ready`=0, `seq_err`=0, `err_stage`=0.
- `stage_ack` bits for stages not yet released are ignored.
- In WAIT_ACK and GAP, an ack drop on an already-released lower stage is ignored. Only RUN monitors ack loss.
- cnt width is $clog2(max(HOLD_CYC, STG_GAP, ACK_TO)). Counters never wrap, because every compare is terminal.

## Timing
- All outputs change only on the rising `clk` edge, except the asynchronous clear on `rst_n`.
- Number edges from 1 = the first rising edge after `rst_n` deassertion:
  - stage 0 releases at edge HOLD_CYC;
  - with acks already high, stage k releases at edge HOLD_CYC + k·(STG_GAP+1);
  - `all_ready` rises one edge after the last release.
- Ack to next-stage release latency: 1 + STG_GAP edges.
- Timeout: FAULT is entered at edge (release edge + ACK_TO) if the ack never arrives.
- Response to soft reset, ack drop in RUN, and timeout: one edge (registered).

## Structure
- `rst_seq_pkg`: `state_t` enum (HOLD, WAIT_ACK, GAP, RUN, FAULT). This module and its bench both use it.
- The single counter is shared across states and lives inline. No sub-module.
- One `always_ff` block for state/cnt/idx/outputs; one combinational next-state block.

## Test plan
Parameters for all scenarios: NUM_STG=4, HOLD_CYC=8, STG_GAP=4, ACK_TO=16.

- **Nominal sequence.** `stage_ack`=4'hF constantly, release `rst_n`. Expect:
  - `stg_rst_n` bits 0..3 rise at edges 8, 13, 18, 23;
  - `all_ready`=1 at edge 24;
  - `seq_err`=0 throughout.
- **Ack timeout.** `stage_ack`=4'b1011, so stage 2 never acks. Expect:
  - stage 2 releases at edge 18;
  - at edge 34, `seq_err`=1, `err_stage`=2, `stg_rst_n`=4'b0011;
  - state then holds indefinitely.
- **Soft reset from RUN.** Pulse `soft_rst_req` in RUN. Expect:
  - next edge: `stg_rst_n`=0, `all_ready`=0;
  - the sequence repeats, with stage 0 releasing 8 edges after the pulse edge.
- **Ack loss in RUN.** Drop `stage_ack[1]` in RUN. Expect next edge: `seq_err`=1, `err_stage`=1, `stg_rst_n`=4'b0001, `all_ready`=0.
- **Async reset mid-GAP.** Assert `rst_n` mid-GAP. Expect all outputs 0 immediately, with no clock edge required; the sequence restarts cleanly after release.
- **Simultaneous events.** `soft_rst_req` asserted on the timeout edge. Expect the soft reset to win: HOLD, with `seq_err` staying 0.
